// File: rtl/serial_pkg.sv
// Shared serial-link definitions: receive FSM states, line levels and default word width.
package serial_pkg;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    localparam int DEFAULT_NBITS_DATA = 4;

endpackage

// File: rtl/rx_out_buffer.sv
// One-entry valid/ready holding register for received words, with overrun detection
// when a completed frame arrives while the held word has not been taken.
module rx_out_buffer import serial_pkg::*; #(
    parameter int NBITS_DATA = DEFAULT_NBITS_DATA
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  commit,
    input  logic [NBITS_DATA-1:0] commit_data,
    input  logic                  commit_perr,
    input  logic                  commit_ferr,
    input  logic                  rx_ready,
    output logic [NBITS_DATA-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun
);

    // A commit wins over a plain handshake: a word leaving and a new one arriving
    // on the same edge simply replaces the held word and keeps rx_valid high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (commit) begin
                if (!rx_valid || rx_ready) begin
                    rx_data    <= commit_data;
                    parity_err <= commit_perr;
                    frame_err  <= commit_ferr;
                    rx_valid   <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, LSB-first data, optional even parity, stop bit.
// The FSM advances only on bit_en cycles; finished words go to a one-entry output buffer.
module serial_frame_rx import serial_pkg::*; #(
    parameter int NBITS_DATA = DEFAULT_NBITS_DATA,
    parameter bit PARITY_EN  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  bit_in,
    input  logic                  bit_en,
    output logic [NBITS_DATA-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  busy
);

    localparam int CNT_W = $clog2(NBITS_DATA + 1);

    rx_state_t             state;
    logic [NBITS_DATA-1:0] shreg;
    logic [CNT_W-1:0]      cnt;
    logic                  perr;
    logic                  commit;
    logic                  ferr;

    // Bits arrive LSB first, so each new bit enters at the top and the word
    // is right-aligned once all NBITS_DATA bits have been shifted in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
            perr  <= 1'b0;
        end else if (bit_en) begin
            case (state)
                IDLE: begin
                    if (bit_in == START_BIT) begin
                        state <= DATA;
                        cnt   <= '0;
                        perr  <= 1'b0;
                    end
                end
                DATA: begin
                    shreg <= {bit_in, shreg[NBITS_DATA-1:1]};
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(NBITS_DATA - 1)) begin
                        state <= PARITY_EN ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    perr  <= ^{shreg, bit_in};
                    state <= STOP;
                end
                STOP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign commit = bit_en && (state == STOP);
    assign ferr   = (bit_in != STOP_BIT);
    assign busy   = (state != IDLE);

    rx_out_buffer #(
        .NBITS_DATA (NBITS_DATA)
    ) u_out_buffer (
        .clk         (clk),
        .reset       (reset),
        .commit      (commit),
        .commit_data (shreg),
        .commit_perr (perr),
        .commit_ferr (ferr),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun     (overrun)
    );

endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx: frames pushed as expected words, monitor pops on handshake.
module tb_serial_frame_rx;

    typedef struct {
        logic [3:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       bit_in = 1'b1;
    logic       bit_en = 1'b0;
    logic [3:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    logic       bit_in2 = 1'b1;
    logic       bit_en2 = 1'b0;
    logic [3:0] rx_data2;
    logic       rx_valid2;
    logic       parity_err2;
    logic       frame_err2;
    logic       overrun2;
    logic       busy2;

    exp_t sb[$];
    exp_t mon_e;
    int   tests_run = 0;
    int   tests_failed = 0;
    int   ov_count = 0;
    bit   ready_random = 1'b0;
    logic ready_value = 1'b1;

    serial_frame_rx #(.NBITS_DATA(4), .PARITY_EN(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .bit_in     (bit_in),
        .bit_en     (bit_en),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    serial_frame_rx #(.NBITS_DATA(4), .PARITY_EN(1'b0)) dut_nopar (
        .clk        (clk),
        .reset      (reset),
        .bit_in     (bit_in2),
        .bit_en     (bit_en2),
        .rx_data    (rx_data2),
        .rx_valid   (rx_valid2),
        .rx_ready   (1'b1),
        .parity_err (parity_err2),
        .frame_err  (frame_err2),
        .overrun    (overrun2),
        .busy       (busy2)
    );

    always #5 clk = ~clk;

    // Consumer side: rx_ready changes just after the active edge only.
    always @(posedge clk) begin
        #2;
        rx_ready = ready_random ? 1'($urandom_range(0, 1)) : ready_value;
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: the held word is the oldest pending frame; a dropped frame is the newest.
    always @(negedge clk) begin
        if (!reset) begin
            if (rx_valid && rx_ready) begin
                if (sb.size() == 0) begin
                    check_output("unexpected_word", 32'(rx_data), 32'hFFFF_FFFF);
                end else begin
                    mon_e = sb.pop_front();
                    check_output("sb_data", 32'(rx_data), 32'(mon_e.data));
                    check_output("sb_parity_err", 32'(parity_err), 32'(mon_e.perr));
                    check_output("sb_frame_err", 32'(frame_err), 32'(mon_e.ferr));
                end
            end
            if (overrun) begin
                ov_count++;
                if (sb.size() == 0) begin
                    check_output("unexpected_overrun", 32'(overrun), 32'h0);
                end else begin
                    mon_e = sb.pop_back();
                end
            end
        end
    end

    task automatic apply_bit(input logic b, input bit gaps);
        bit_in = b;
        bit_en = 1'b1;
        @(posedge clk); #1;
        if (gaps) begin
            bit_en = 1'b0;
            bit_in = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
    endtask

    // Reference: even parity means the total count of ones over data and parity bit is even.
    task automatic apply_stimulus(input logic [3:0] data, input logic pbit, input logic sbit, input bit gaps);
        exp_t e;
        e.data = data;
        e.perr = ((($countones(data) + int'(pbit)) % 2) == 1);
        e.ferr = (sbit == 1'b0);
        sb.push_back(e);
        apply_bit(1'b0, gaps);
        for (int i = 0; i < 4; i++) apply_bit(data[i], gaps);
        apply_bit(pbit, gaps);
        apply_bit(sbit, gaps);
        bit_en = 1'b0;
        bit_in = 1'b1;
    endtask

    task automatic send_nopar(input logic [5:0] bits);
        for (int i = 0; i < 6; i++) begin
            bit_in2 = bits[i];
            bit_en2 = 1'b1;
            @(posedge clk); #1;
        end
        bit_en2 = 1'b0;
        bit_in2 = 1'b1;
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int ov0;
        logic [3:0] d;
        logic p;
        logic s;
        logic [5:0] np_bits;

        repeat (3) @(posedge clk);
        #1;
        check_output("reset_rx_valid", 32'(rx_valid), 32'h0);
        check_output("reset_rx_data", 32'(rx_data), 32'h0);
        check_output("reset_flags", 32'({parity_err, frame_err, overrun}), 32'h0);
        check_output("reset_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        ready_value = 1'b1;
        apply_stimulus(4'hB, 1'b1, 1'b1, 1'b0);
        check_output("frame_b_valid", 32'(rx_valid), 32'h1);
        check_output("frame_b_data", 32'(rx_data), 32'hB);
        check_output("frame_b_flags", 32'({parity_err, frame_err}), 32'h0);

        apply_stimulus(4'hB, 1'b0, 1'b1, 1'b0);
        check_output("bad_parity_data", 32'(rx_data), 32'hB);
        check_output("bad_parity_flag", 32'(parity_err), 32'h1);

        apply_stimulus(4'hB, 1'b1, 1'b0, 1'b0);
        check_output("bad_stop_flags", 32'({parity_err, frame_err}), 32'h1);
        @(posedge clk); #1;

        ready_value = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        ov0 = ov_count;
        apply_stimulus(4'h3, 1'b0, 1'b1, 1'b0);
        apply_stimulus(4'hC, 1'b0, 1'b1, 1'b0);
        check_output("hold_data_after_2nd", 32'(rx_data), 32'h3);
        repeat (3) @(posedge clk);
        #1;
        check_output("overrun_pulses", 32'(ov_count - ov0), 32'h1);
        check_output("hold_valid", 32'(rx_valid), 32'h1);
        check_output("hold_data_stable", 32'(rx_data), 32'h3);
        ready_value = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_output("release_valid_low", 32'(rx_valid), 32'h0);
        check_output("release_sb_empty", 32'(sb.size()), 32'h0);

        apply_stimulus(4'h5, 1'b0, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check_output("toggle_en_sb_empty", 32'(sb.size()), 32'h0);
        check_output("toggle_en_data", 32'(rx_data), 32'h5);

        apply_bit(1'b0, 1'b0);
        apply_bit(1'b1, 1'b0);
        apply_bit(1'b0, 1'b0);
        bit_en = 1'b0;
        check_output("midframe_busy", 32'(busy), 32'h1);
        reset = 1'b1;
        @(posedge clk); #1;
        check_output("midreset_busy", 32'(busy), 32'h0);
        check_output("midreset_valid", 32'(rx_valid), 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;
        apply_stimulus(4'h9, 1'b0, 1'b1, 1'b0);
        check_output("after_reset_data", 32'(rx_data), 32'h9);
        check_output("after_reset_flags", 32'({parity_err, frame_err}), 32'h0);
        @(posedge clk); #1;
        check_output("after_reset_sb_empty", 32'(sb.size()), 32'h0);

        np_bits = 6'b101100;
        send_nopar(np_bits);
        check_output("nopar_valid", 32'(rx_valid2), 32'h1);
        check_output("nopar_data", 32'(rx_data2), 32'h6);
        check_output("nopar_flags", 32'({parity_err2, frame_err2}), 32'h0);
        bit_in2 = 1'b1;
        bit_en2 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check_output("nopar_idle_busy", 32'(busy2), 32'h0);
        end
        bit_en2 = 1'b0;

        ready_random = 1'b1;
        for (int f = 0; f < 40; f++) begin
            d = 4'($urandom_range(0, 15));
            p = 1'($countones(d) % 2);
            if ($urandom_range(0, 3) == 0) p = ~p;
            s = ($urandom_range(0, 9) == 0) ? 1'b0 : 1'b1;
            apply_stimulus(d, p, s, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) begin
                bit_in = 1'b1;
                bit_en = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
            bit_en = 1'b0;
        end

        ready_random = 1'b0;
        ready_value = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check_output("drain_sb_empty", 32'(sb.size()), 32'h0);
        @(posedge clk); #1;
        check_output("drain_valid_low", 32'(rx_valid), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
